// File: rtl/add_sub_pkg.sv
// add_sub_pkg
// Shared definitions for the bit-serial adder/subtractor: the controller
// state encoding and the mode constants used on the mode input.
package add_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/fa_fs_bit.sv
// fa_fs_bit
// One-bit full adder / full subtractor cell.
//   x, y   : operand bits
//   cbin   : carry-in (add) or borrow-in (subtract)
//   mode   : MODE_ADD computes x+y, MODE_SUB computes x-y
//   r      : sum / difference bit
//   cbout  : carry-out (add) or borrow-out (subtract)
module fa_fs_bit
    import add_sub_pkg::*;
(
    input  logic x,
    input  logic y,
    input  logic cbin,
    input  logic mode,
    output logic r,
    output logic cbout
);

    logic xy_diff;

    assign xy_diff = x ^ y;

    // Sum and difference bits are the same XOR; only the carry/borrow differs.
    assign r = xy_diff ^ cbin;

    always_comb begin
        if (mode == MODE_SUB) begin
            cbout = (~x & y) | (cbin & ~xy_diff);
        end else begin
            cbout = (x & y) | (cbin & xy_diff);
        end
    end

endmodule

// File: rtl/serial_add_sub.sv
// serial_add_sub
// Bit-serial two's-complement adder/subtractor. One operand bit is processed
// per clock, LSB first, through a single fa_fs_bit cell.
//   clk, rst      : clock, asynchronous active-high reset
//   start         : request an operation (accepted only when idle)
//   mode          : 0 = a+b, 1 = a-b (latched with start)
//   a, b          : operands (latched with start)
//   busy          : operation in progress
//   done          : one-cycle pulse when result/cout/ovf are updated
//   result        : sum or difference, held until the next done
//   cout          : carry out (add) or borrow out (subtract)
//   ovf           : signed overflow
// Latency: start accepted at edge E, done high after edge E+WIDTH, idle again
// after edge E+WIDTH+1.
module serial_add_sub
    import add_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf
);

    localparam int                 CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_sh_q, a_sh_d;
    logic [WIDTH-1:0]   b_sh_q, b_sh_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               cb_q, cb_d;
    logic               mode_q, mode_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;

    logic               cell_r;
    logic               cell_cb;

    fa_fs_bit u_cell (
        .x     (a_sh_q[0]),
        .y     (b_sh_q[0]),
        .cbin  (cb_q),
        .mode  (mode_q),
        .r     (cell_r),
        .cbout (cell_cb)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            cb_q     <= 1'b0;
            mode_q   <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            cb_q     <= cb_d;
            mode_q   <= mode_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        cb_d     = cb_q;
        mode_d   = mode_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    mode_d  = mode;
                    acc_d   = '0;
                    cnt_d   = '0;
                    cb_d    = 1'b0;
                    state_d = RUN;
                end
            end

            RUN: begin
                // Operands shift right so bit 0 always feeds the cell; the
                // result bit enters at the MSB so after WIDTH shifts it is
                // in its final position.
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                acc_d  = {cell_r, acc_q[WIDTH-1:1]};
                cb_d   = cell_cb;
                if (cnt_q == CNT_LAST) begin
                    state_d  = DONE;
                    result_d = acc_d;
                    cout_d   = cell_cb;
                    // On the last bit the cell inputs are the operand MSBs.
                    if (mode_q == MODE_SUB) begin
                        ovf_d = (a_sh_q[0] != b_sh_q[0]) && (cell_r != a_sh_q[0]);
                    end else begin
                        ovf_d = (a_sh_q[0] == b_sh_q[0]) && (cell_r != a_sh_q[0]);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy   = (state_q == RUN);
    assign done   = (state_q == DONE);
    assign result = result_q;
    assign cout   = cout_q;
    assign ovf    = ovf_q;

endmodule

// File: tb/tb_serial_add_sub.sv
// tb_serial_add_sub
// Runs three serial_add_sub instances (WIDTH 2, 8, 17) from shared stimulus.
// Hand-computed WIDTH=8 vectors, multi-cycle corner sequences (ignored start,
// mid-operation reset, back-to-back start), and a random regression checked
// against an arithmetic reference model.
module tb_serial_add_sub;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        mode;
    logic [63:0] a_in;
    logic [63:0] b_in;

    logic [2:0]  busy_v, done_v, cout_v, ovf_v;
    logic [1:0]  r2;
    logic [7:0]  r8;
    logic [16:0] r17;

    int n_chk  = 0;
    int n_fail = 0;

    logic [63:0] prev_r [3];
    logic        prev_c [3];
    logic        prev_o [3];

    typedef struct {
        logic       m;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] r;
        logic       c;
        logic       o;
    } vec_t;

    vec_t tbl [9];

    always #5 clk = ~clk;

    serial_add_sub #(.WIDTH(2)) u_w2 (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .a(a_in[1:0]), .b(b_in[1:0]),
        .busy(busy_v[0]), .done(done_v[0]), .result(r2),
        .cout(cout_v[0]), .ovf(ovf_v[0])
    );

    serial_add_sub #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .a(a_in[7:0]), .b(b_in[7:0]),
        .busy(busy_v[1]), .done(done_v[1]), .result(r8),
        .cout(cout_v[1]), .ovf(ovf_v[1])
    );

    serial_add_sub #(.WIDTH(17)) u_w17 (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .a(a_in[16:0]), .b(b_in[16:0]),
        .busy(busy_v[2]), .done(done_v[2]), .result(r17),
        .cout(cout_v[2]), .ovf(ovf_v[2])
    );

    function automatic int wid(input int i);
        case (i)
            0:       return 2;
            1:       return 8;
            default: return 17;
        endcase
    endfunction

    function automatic logic [63:0] get_res(input int i);
        case (i)
            0:       return {62'b0, r2};
            1:       return {56'b0, r8};
            default: return {47'b0, r17};
        endcase
    endfunction

    function automatic void model(input int w, input logic m,
                                  input logic [63:0] a, input logic [63:0] b,
                                  output logic [63:0] r, output logic c,
                                  output logic o);
        logic [63:0] mask;
        logic [63:0] am, bm;
        logic [64:0] s;
        logic        sa, sb, sr;
        mask = (64'd1 << w) - 64'd1;
        am   = a & mask;
        bm   = b & mask;
        if (!m) begin
            s = {1'b0, am} + {1'b0, bm};
            r = s[63:0] & mask;
            c = s[w];
        end else begin
            r = (am - bm) & mask;
            c = (am < bm);
        end
        sa = am[w-1];
        sb = bm[w-1];
        sr = r[w-1];
        o  = m ? ((sa != sb) && (sr != sa)) : ((sa == sb) && (sr != sa));
    endfunction

    task automatic chk(input string nm, input int w,
                       input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (W=%0d): got %0h expected %0h at %0t", nm, w, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string nm);
        for (int i = 0; i < 3; i++) begin
            chk({nm, "_busy"}, wid(i), busy_v[i], 0);
            chk({nm, "_done"}, wid(i), done_v[i], 0);
            chk({nm, "_res"},  wid(i), get_res(i), 0);
            chk({nm, "_cout"}, wid(i), cout_v[i], 0);
            chk({nm, "_ovf"},  wid(i), ovf_v[i], 0);
        end
    endtask

    task automatic clear_prev();
        for (int i = 0; i < 3; i++) begin
            prev_r[i] = '0;
            prev_c[i] = 1'b0;
            prev_o[i] = 1'b0;
        end
    endtask

    // Pulse reset and realign all instances in IDLE with zeroed outputs.
    task automatic resync();
        rst = 1'b1;
        start = 1'b0;
        #1;
        check_all_zero("rst");
        tick();
        tick();
        rst = 1'b0;
        clear_prev();
    endtask

    // One operation on all instances, with cycle-by-cycle busy/done timing,
    // hold of the previous outputs while running, and final values.
    task automatic run_all(input logic m, input logic [63:0] a, input logic [63:0] b);
        logic [63:0] er [3];
        logic        ec [3];
        logic        eo [3];
        int          w;
        for (int i = 0; i < 3; i++) model(wid(i), m, a, b, er[i], ec[i], eo[i]);
        mode  = m;
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k <= 18; k++) begin
            for (int i = 0; i < 3; i++) begin
                w = wid(i);
                chk("busy", w, busy_v[i], (k < w));
                chk("done", w, done_v[i], (k == w));
                if (k < w) begin
                    chk("hold_res",  w, get_res(i), prev_r[i]);
                    chk("hold_cout", w, cout_v[i], prev_c[i]);
                    chk("hold_ovf",  w, ovf_v[i], prev_o[i]);
                end else begin
                    chk("res",  w, get_res(i), er[i]);
                    chk("cout", w, cout_v[i], ec[i]);
                    chk("ovf",  w, ovf_v[i], eo[i]);
                end
            end
            if (k < 18) tick();
        end
        for (int i = 0; i < 3; i++) begin
            prev_r[i] = er[i];
            prev_c[i] = ec[i];
            prev_o[i] = eo[i];
        end
    endtask

    initial begin
        int d1, d2, ndone;

        tbl[0] = '{1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1};
        tbl[1] = '{1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
        tbl[2] = '{1'b1, 8'h05, 8'h0A, 8'hFB, 1'b1, 1'b0};
        tbl[3] = '{1'b1, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
        tbl[4] = '{1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 8'h3C, 8'h0F, 8'h4B, 1'b0, 1'b0};
        tbl[6] = '{1'b0, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1};
        tbl[7] = '{1'b1, 8'h00, 8'h01, 8'hFF, 1'b1, 1'b0};
        tbl[8] = '{1'b1, 8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1};

        rst   = 1'b1;
        start = 1'b0;
        mode  = 1'b0;
        a_in  = '0;
        b_in  = '0;
        clear_prev();

        #3;
        check_all_zero("por");
        tick();
        tick();
        rst = 1'b0;

        // Hand-computed WIDTH=8 vectors; first start right after reset release.
        for (int i = 0; i < 9; i++) begin
            run_all(tbl[i].m, {56'b0, tbl[i].a}, {56'b0, tbl[i].b});
            chk("tbl_res",  8, get_res(1), {56'b0, tbl[i].r});
            chk("tbl_cout", 8, cout_v[1], tbl[i].c);
            chk("tbl_ovf",  8, ovf_v[1], tbl[i].o);
        end

        // start pulsed mid-operation with different operands must be ignored.
        resync();
        mode  = 1'b0;
        a_in  = 64'h12;
        b_in  = 64'h34;
        start = 1'b1;
        tick();
        start = 1'b0;
        ndone = 0;
        for (int k = 0; k <= 18; k++) begin
            if (k == 2) begin
                a_in  = 64'hFF;
                b_in  = 64'hFF;
                mode  = 1'b1;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done_v[1]) ndone++;
            if (k >= 8) begin
                chk("ign_res",  8, get_res(1), 64'h46);
                chk("ign_cout", 8, cout_v[1], 0);
                chk("ign_ovf",  8, ovf_v[1], 0);
            end
            if (k < 18) tick();
        end
        start = 1'b0;
        chk("ign_done_count", 8, ndone, 1);

        // Reset four edges into an operation: outputs clear immediately and
        // no done pulse follows.
        resync();
        run_all(1'b0, 64'h0001_2345, 64'h0000_4321);
        mode  = 1'b0;
        a_in  = 64'h55;
        b_in  = 64'h22;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 4; k++) tick();
        rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("rst_no_done", 8, done_v[1], 0);
            chk("rst_no_busy", 8, busy_v[1], 0);
        end
        rst = 1'b0;
        clear_prev();
        run_all(1'b0, 64'h0F, 64'h01);
        chk("post_rst_res", 8, get_res(1), 64'h10);

        // start held high: next op accepted WIDTH+2 cycles after the first.
        resync();
        mode  = 1'b0;
        a_in  = 64'h7F;
        b_in  = 64'h01;
        start = 1'b1;
        tick();
        a_in  = 64'h10;
        b_in  = 64'h20;
        d1 = -1;
        d2 = -1;
        for (int k = 0; k <= 24; k++) begin
            if (done_v[1]) begin
                if (d1 < 0) begin
                    d1 = k;
                    chk("b2b_res1", 8, get_res(1), 64'h80);
                    chk("b2b_ovf1", 8, ovf_v[1], 1);
                end else if (d2 < 0) begin
                    d2 = k;
                    chk("b2b_res2", 8, get_res(1), 64'h30);
                    chk("b2b_ovf2", 8, ovf_v[1], 0);
                end
            end
            if (k < 24) tick();
        end
        start = 1'b0;
        chk("b2b_done1_cycle", 8, d1, 8);
        chk("b2b_done2_cycle", 8, d2, 18);

        // Random regression across all three widths.
        resync();
        for (int n = 0; n < 30; n++) begin
            run_all(1'($urandom_range(0, 1)), {$urandom, $urandom}, {$urandom, $urandom});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
